sim_ctrl_mmio: RTL and testbench
================================

// Module: sim_ctrl_mmio
// PURPOSE
//   Memory-mapped test-control responder on the CPU data-memory bus. Accepts CPU
//   stores to a small register window and latches the program's end-of-test verdict
//   (TOHOST). Buffers console bytes in a FIFO that the bench or a UART drains.
//   Runs a cycle counter and watchdog, so self-checking programs need no bench probing.
// PARAMETERS
//   BASE_ADDR       32'h0000_0100  16-byte-aligned base of register window
//   FIFO_DEPTH      8              console FIFO entries; power of 2, >=2
//   TIMEOUT_CYCLES  1000           watchdog limit in RUN cycles; 0 disables
// PORTS
//   clk         in   1   clock, rising edge
//   reset       in   1   synchronous, active-low reset
//   req_valid   in   1   bus request this cycle
//   req_write   in   1   1=store, 0=load
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data
//   rsp_valid   out  1   load data valid (one cycle after load request)
//   rsp_rdata   out  32  load data
//   con_valid   out  1   console byte available
//   con_ready   in   1   consumer accepts byte
//   con_data    out  8   console byte (FIFO head)
//   done        out  1   state != RUN
//   pass        out  1   state == PASS
//   fail_code   out  31  code latched on FAIL; 0 otherwise
//   timeout     out  1   state == TIMEOUT
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=RUN; cycle_cnt=0; FIFO empty; sticky flags 0.
//   All outputs 0 in the following cycle. Mid-operation reset discards FIFO and verdict.
// - Decode: hit = req_valid && req_addr[31:4]==BASE_ADDR[31:4]. Register is req_addr[3:2].
//   Register map:
//   0x0 TOHOST   W: wdata==1 -> PASS; wdata[0]==1, wdata!=1 -> FAIL with
//                fail_code=wdata[31:1]; wdata[0]==0 ignored. R: 0.
//   0x4 CONSOLE  W: push wdata[7:0]. R: 0.
//   0x8 CYCLE    R: cycle_cnt. W ignored.
//   0xC STATUS   R: [1:0] state (00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT), [2] full,
//                [3] overflow, [4] misalign, [15:8] FIFO count. Other bits 0. W ignored.
// - Loads: rsp_valid=1 exactly one cycle after each load hit. rsp_rdata is registered
//   and holds its value otherwise. Loads outside the window produce no response.
// - State machine RUN -> {PASS, FAIL, TIMEOUT}. Terminal states are sticky until
//   reset. TOHOST writes in a terminal state are ignored.
// - cycle_cnt increments every RUN cycle, freezes on leaving RUN, saturates at
//   32'hFFFF_FFFF.
// - Watchdog: when TIMEOUT_CYCLES!=0 and cycle_cnt==TIMEOUT_CYCLES-1 in RUN, go to
//   TIMEOUT next cycle. Same-cycle TOHOST write takes priority over timeout.
// - FIFO: con_valid = !empty; pop when con_valid && con_ready.
//   - Push when full with no pop: byte dropped, overflow sticky set.
//   - Push and pop when full: both occur, count unchanged.
//   - Push when empty: byte visible on con_data the next cycle (no bypass).
//   - Pointers wrap modulo FIFO_DEPTH. Count is FIFO_DEPTH when full.
//   - Console pushes remain accepted after done.
// - Misaligned hit (req_addr[1:0]!=0): misalign sticky set. The access is otherwise
//   decoded on req_addr[3:2] unless trap is enabled.
// CONFIGURATION
//   SIMCTRL_MISALIGN_TRAP_EN defined: a misaligned hit in RUN is not performed and
//   forces FAIL with fail_code=31'h7FFF_FFFF. Misaligned loads return rsp_rdata=0.
//   Undefined: no trap. Only the STATUS[4] flag records the event.
// TESTING
//   1 reset low 2 cycles, release; read STATUS -> 0x00000000; read CYCLE after 10
//     cycles -> ~10, rsp_valid exactly 1 cycle after each load.
//   2 store 0x48,0x69 to CONSOLE, con_ready=1 -> con_data 0x48 then 0x69, con_valid
//     drops after. Store TOHOST=1 -> done=1, pass=1, CYCLE frozen.
//   3 store TOHOST=0x0000000B -> FAIL, fail_code=5. Later TOHOST=1 -> stays FAIL.
//   4 con_ready=0, push 9 bytes (depth 8) -> STATUS[2]=1, [3]=1, [15:8]=8, first 8
//     bytes drained in order. Push+pop while full -> count stays 8.
//   5 TIMEOUT_CYCLES=20, no TOHOST -> timeout=1 at cycle 20, CYCLE reads 20.
//     TOHOST=1 in the same cycle as expiry -> pass wins.
//   6 store to BASE_ADDR+0x2: trap build -> FAIL, code 0x7FFFFFFF. Default build ->
//     STATUS[4]=1, state RUN.

Source files
------------

// File: rtl/sim_ctrl_mmio.sv
// Test-control MMIO responder: TOHOST verdict, console FIFO, cycle counter, watchdog.
// Optional build macro SIMCTRL_MISALIGN_TRAP_EN turns misaligned hits in RUN into FAIL.
module sim_ctrl_mmio #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0100,
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        con_valid,
   input  logic        con_ready,
   output logic [7:0]  con_data,
   output logic        done,
   output logic        pass,
   output logic [30:0] fail_code,
   output logic        timeout
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [31:0]   TO_LAST  = TIMEOUT_CYCLES - 32'd1;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_PASS    = 2'b01,
      ST_FAIL    = 2'b10,
      ST_TIMEOUT = 2'b11
   } state_e;

   state_e        state_q, state_d;
   logic [30:0]   fail_q, fail_d;
   logic [31:0]   cyc_q, cyc_d;
   logic          rsp_valid_q;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          mis_q, mis_d;
   logic [7:0]    mem [FIFO_DEPTH];

   logic        hit, misal, trap, wr_hit, rd_hit;
   logic        tohost_we, con_we;
   logic        full, empty, push, pop;
   logic [1:0]  sel;
   logic [7:0]  cnt8;
   logic [31:0] status, rdata;

   assign hit   = req_valid && (req_addr[31:4] == BASE_ADDR[31:4]);
   assign misal = hit && (req_addr[1:0] != 2'b00);
   assign sel   = req_addr[3:2];

`ifdef SIMCTRL_MISALIGN_TRAP_EN
   assign trap = misal && (state_q == ST_RUN);
`else
   assign trap = 1'b0;
`endif

   assign wr_hit    = hit && req_write && !trap;
   assign rd_hit    = hit && !req_write;
   assign tohost_we = wr_hit && (sel == 2'd0);
   assign con_we    = wr_hit && (sel == 2'd1);

   assign full  = (cnt_q == CNT_FULL);
   assign empty = (cnt_q == '0);
   assign pop   = !empty && con_ready;
   // A full FIFO still takes a byte when the head leaves in the same cycle.
   assign push  = con_we && (!full || pop);

   always_comb begin
      state_d = state_q;
      fail_d  = fail_q;
      if (state_q == ST_RUN) begin
         if (trap) begin
            state_d = ST_FAIL;
            fail_d  = '1;
         end else if (tohost_we && req_wdata == 32'd1) begin
            state_d = ST_PASS;
         end else if (tohost_we && req_wdata[0]) begin
            state_d = ST_FAIL;
            fail_d  = req_wdata[31:1];
         end else if (TIMEOUT_CYCLES != 0 && cyc_q == TO_LAST) begin
            state_d = ST_TIMEOUT;
         end
      end
   end

   always_comb begin
      cyc_d = cyc_q;
      if (state_q == ST_RUN && cyc_q != 32'hFFFF_FFFF) begin
         cyc_d = cyc_q + 32'd1;
      end
   end

   assign cnt8   = 8'(cnt_q);
   assign status = {16'h0, cnt8, 3'b000, mis_q, ovf_q, full, state_q};

   always_comb begin
      rdata = 32'h0;
      case (sel)
         2'd2:    rdata = cyc_q;
         2'd3:    rdata = status;
         default: rdata = 32'h0;
      endcase
`ifdef SIMCTRL_MISALIGN_TRAP_EN
      if (misal) rdata = 32'h0;
`endif
      rsp_rdata_d = rd_hit ? rdata : rsp_rdata_q;
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      cnt_d    = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
      ovf_d = ovf_q | (con_we && full && !pop);
      mis_d = mis_q | misal;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         fail_q      <= '0;
         cyc_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         mis_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         fail_q      <= fail_d;
         cyc_q       <= cyc_d;
         rsp_valid_q <= rd_hit;
         rsp_rdata_q <= rsp_rdata_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         mis_q       <= mis_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= req_wdata[7:0];
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign con_valid = !empty;
   assign con_data  = empty ? 8'h00 : mem[rd_ptr_q];
   assign done      = (state_q != ST_RUN);
   assign pass      = (state_q == ST_PASS);
   assign timeout   = (state_q == ST_TIMEOUT);
   assign fail_code = fail_q;

endmodule

// File: tb/tb_sim_ctrl_mmio.sv
// Scoreboard bench for sim_ctrl_mmio: load responses and console bytes are queued
// when driven and compared when the DUT emits them; a 20-cycle watchdog copy shares the bus.
module tb_sim_ctrl_mmio;

   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam logic [31:0] A_TH = BASE + 32'h0;
   localparam logic [31:0] A_CO = BASE + 32'h4;
   localparam logic [31:0] A_CY = BASE + 32'h8;
   localparam logic [31:0] A_ST = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        con_ready = 1'b0;

   logic        rsp_valid, con_valid, done, pass, timeout;
   logic [31:0] rsp_rdata;
   logic [7:0]  con_data;
   logic [30:0] fail_code;

   logic        w_rsp_valid, w_con_valid, w_done, w_pass, w_timeout;
   logic [31:0] w_rsp_rdata;
   logic [7:0]  w_con_data;
   logic [30:0] w_fail_code;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] sb[$];
   logic [7:0]  con_q[$];
   logic        ld_now = 1'b0;
   logic        ld_prev = 1'b0;
   logic        mon_en = 1'b0;
   logic        m_run = 1'b1;
   logic [31:0] m_cnt = '0;

   always #5 clk = ~clk;

   sim_ctrl_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(1000)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data),
      .done(done), .pass(pass), .fail_code(fail_code), .timeout(timeout)
   );

   sim_ctrl_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(20)) u_wd (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(w_rsp_valid), .rsp_rdata(w_rsp_rdata),
      .con_valid(w_con_valid), .con_ready(1'b1), .con_data(w_con_data),
      .done(w_done), .pass(w_pass), .fail_code(w_fail_code), .timeout(w_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference cycle counter: counts every post-reset edge while the verdict is open.
   always @(posedge clk) begin
      if (!reset) m_cnt <= '0;
      else if (m_run && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
      ld_prev <= ld_now;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, ld_prev});
         if (rsp_valid && sb.size() > 0) chk("rsp_rdata", rsp_rdata, sb.pop_front());
         if (con_valid && con_ready) begin
            if (con_q.size() == 0) chk("con_extra", 32'(con_data), 32'hFFFF_FFFF);
            else chk("con_data", 32'(con_data), 32'(con_q.pop_front()));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      m_run = 1'b1;
      sb.delete();
      con_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = a;
      ld_now    = (a[31:4] == BASE[31:4]);
      if (ld_now) sb.push_back(exp);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      ld_now    = 1'b0;
   endtask

   initial begin
      int n;
      do_reset();

      // reset state and basic loads
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_pass", {31'b0, pass}, 32'd0);
      chk("rst_tmo", {31'b0, timeout}, 32'd0);
      chk("rst_fcode", {1'b0, fail_code}, 32'd0);
      chk("rst_conv", {31'b0, con_valid}, 32'd0);
      chk("rst_cond", 32'(con_data), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      rd(A_ST, 32'h0);
      rd(A_TH, 32'h0);
      rd(A_CO, 32'h0);
      rd(32'h0000_0200, 32'h0);
      rd(BASE + 32'h10, 32'h0);
      idle(10);
      rd(A_CY, m_cnt);

      // console output and PASS
      con_ready = 1'b1;
      con_q.push_back(8'h48);
      wr(A_CO, 32'h48);
      con_q.push_back(8'h69);
      wr(A_CO, 32'h69);
      wr(A_TH, 32'h2);
      idle(3);
      chk("con_drained", {31'b0, con_valid}, 32'd0);
      chk("con_q_empty", 32'(con_q.size()), 32'd0);
      chk("even_ignored", {31'b0, done}, 32'd0);
      wr(A_TH, 32'h1);
      m_run = 1'b0;
      chk("pass_done", {31'b0, done}, 32'd1);
      chk("pass_pass", {31'b0, pass}, 32'd1);
      chk("pass_fcode", {1'b0, fail_code}, 32'd0);
      rd(A_ST, 32'h1);
      idle(5);
      rd(A_CY, m_cnt);
      con_ready = 1'b0;

      // FAIL verdict is sticky
      do_reset();
      wr(A_TH, 32'h0000_000B);
      m_run = 1'b0;
      chk("fail_fcode", {1'b0, fail_code}, 32'd5);
      chk("fail_done", {31'b0, done}, 32'd1);
      chk("fail_pass", {31'b0, pass}, 32'd0);
      wr(A_TH, 32'h1);
      chk("fail_sticky", {31'b0, pass}, 32'd0);
      chk("fail_fcode2", {1'b0, fail_code}, 32'd5);
      rd(A_ST, 32'h2);

      // FIFO full, overflow, push+pop at full
      do_reset();
      for (int i = 0; i < 9; i++) begin
         if (i < 8) con_q.push_back(8'(8'hA0 + i));
         wr(A_CO, 32'hA0 + 32'(i));
      end
      rd(A_ST, 32'h0000_080C);
      con_ready = 1'b1;
      con_q.push_back(8'hEE);
      wr(A_CO, 32'hEE);
      con_ready = 1'b0;
      rd(A_ST, 32'h0000_080C);
      con_ready = 1'b1;
      n = 0;
      while (con_q.size() > 0 && n < 40) begin
         idle(1);
         n++;
      end
      chk("drain_bound", {31'b0, n < 40}, 32'd1);
      idle(1);
      chk("drain_conv", {31'b0, con_valid}, 32'd0);
      con_ready = 1'b0;
      rd(A_ST, 32'h0000_0008);

      // watchdog on the 20-cycle copy
      do_reset();
      n = 0;
      while (!w_timeout && n < 100) begin
         idle(1);
         n++;
      end
      chk("wd_cycles", 32'(n), 32'd20);
      chk("wd_done", {31'b0, w_done}, 32'd1);
      chk("wd_pass", {31'b0, w_pass}, 32'd0);
      rd(A_CY, m_cnt);
      chk("wd_rspv", {31'b0, w_rsp_valid}, 32'd1);
      chk("wd_cycle", w_rsp_rdata, 32'd20);

      // TOHOST in the expiry cycle wins
      do_reset();
      idle(19);
      wr(A_TH, 32'h1);
      m_run = 1'b0;
      chk("wd_race_pass", {31'b0, w_pass}, 32'd1);
      chk("wd_race_tmo", {31'b0, w_timeout}, 32'd0);

      // misaligned hit
      do_reset();
      wr(BASE + 32'h2, 32'h0);
`ifdef SIMCTRL_MISALIGN_TRAP_EN
      m_run = 1'b0;
      chk("mis_fcode", {1'b0, fail_code}, 32'h7FFF_FFFF);
      rd(A_ST, 32'h12);
`else
      chk("mis_done", {31'b0, done}, 32'd0);
      rd(A_ST, 32'h10);
`endif

      idle(3);
      chk("sb_left", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
